// File: rtl/div_share_arb.sv
// Round-robin sequencer sharing one iterative divider among NUM_REQ requesters.
// One operation in flight at a time; results are returned as a one-cycle one-hot response.
module div_share_arb #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = WIDTH + 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_x_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_y_i,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    output logic [WIDTH-1:0]         rsp_q_o,
    output logic [WIDTH-1:0]         rsp_r_o,
    output logic                     rsp_dbz_o,
    output logic                     rsp_err_o,
    output logic                     div_start_o,
    output logic [WIDTH-1:0]         div_x_o,
    output logic [WIDTH-1:0]         div_y_o,
    input  logic                     div_busy_i,
    input  logic                     div_valid_i,
    input  logic                     div_dbz_i,
    input  logic [WIDTH-1:0]         div_q_i,
    input  logic [WIDTH-1:0]         div_r_i
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StRun,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic [IdxW-1:0]  rr_q, rr_d;
    logic [IdxW-1:0]  owner_q, owner_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;
    logic             err_q, err_d;
    logic [CntW-1:0]  wd_q, wd_d;

    logic             grant_any;
    logic [IdxW-1:0]  grant_idx;
    int unsigned      search_idx;
    logic [WIDTH-1:0] sel_x, sel_y;

    // Busy is informational only; the FSM tracks the divider through start/valid.
    logic unused_busy;
    assign unused_busy = div_busy_i;

    // First requester above the last grant, wrapping, so nobody waits more than NUM_REQ-1 grants.
    always_comb begin
        grant_any  = 1'b0;
        grant_idx  = '0;
        search_idx = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            search_idx = (32'(rr_q) + i) % NUM_REQ;
            if (!grant_any && req_valid_i[IdxW'(search_idx)]) begin
                grant_any = 1'b1;
                grant_idx = IdxW'(search_idx);
            end
        end
    end

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == IdxW'(k)) begin
                sel_x = req_x_i[k*WIDTH +: WIDTH];
                sel_y = req_y_i[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        x_d         = x_q;
        y_d         = y_q;
        q_d         = q_q;
        r_d         = r_q;
        dbz_d       = dbz_q;
        err_d       = err_q;
        wd_d        = wd_q;
        div_start_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_any) begin
                    state_d = StIssue;
                    rr_d    = grant_idx;
                    owner_d = grant_idx;
                    x_d     = sel_x;
                    y_d     = sel_y;
                    q_d     = '0;
                    r_d     = '0;
                    dbz_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            StIssue: begin
                div_start_o = 1'b1;
                state_d     = StWait;
            end
            StWait: begin
                // The divider's dbz flag is sticky, so it is only trusted right after start.
                if (div_dbz_i) begin
                    dbz_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    wd_d    = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (div_valid_i) begin
                    q_d     = div_q_i;
                    r_d     = div_r_i;
                    state_d = StResp;
                end else if (wd_q == CntW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    wd_d = wd_q + CntW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            rr_q    <= IdxW'(NUM_REQ - 1);
            owner_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            x_q     <= x_d;
            y_q     <= y_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_q_o     = '0;
        rsp_r_o     = '0;
        rsp_dbz_o   = 1'b0;
        rsp_err_o   = 1'b0;
        if (state_q == StIdle && grant_any && !reset) begin
            req_ready_o = NUM_REQ'(1) << grant_idx;
        end
        if (state_q == StResp) begin
            rsp_valid_o = NUM_REQ'(1) << owner_q;
            rsp_q_o     = q_q;
            rsp_r_o     = r_q;
            rsp_dbz_o   = dbz_q;
            rsp_err_o   = err_q;
        end
    end

    assign div_x_o = x_q;
    assign div_y_o = y_q;

endmodule

// File: tb/tb_div_share_arb.sv
// Bench for div_share_arb: behavioural divider stub plus a cycle-level reference model of
// grant order, response latency and results, driven by directed and random requests.
module tb_div_share_arb;

    localparam int WIDTH   = 16;
    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = WIDTH + 8;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_x;
    logic [NUM_REQ*WIDTH-1:0] req_y;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_q, rsp_r;
    logic                     rsp_dbz, rsp_err;
    logic                     div_start;
    logic [WIDTH-1:0]         div_x, div_y;
    logic                     div_busy, div_valid, div_dbz;
    logic [WIDTH-1:0]         div_q, div_r;

    div_share_arb #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_x_i    (req_x),
        .req_y_i    (req_y),
        .rsp_valid_o(rsp_valid),
        .rsp_q_o    (rsp_q),
        .rsp_r_o    (rsp_r),
        .rsp_dbz_o  (rsp_dbz),
        .rsp_err_o  (rsp_err),
        .div_start_o(div_start),
        .div_x_o    (div_x),
        .div_y_o    (div_y),
        .div_busy_i (div_busy),
        .div_valid_i(div_valid),
        .div_dbz_i  (div_dbz),
        .div_q_i    (div_q),
        .div_r_i    (div_r)
    );

    always #5 clk = ~clk;

    // Divider stub: result pulse WIDTH+1 cycles after start; sticky dbz; optional hang/inject.
    logic             hang = 1'b0;
    logic             inj  = 1'b0;
    logic [WIDTH-1:0] s_x, s_y;
    int               s_cnt;
    logic             s_run;
    assign div_busy = s_run;

    always @(posedge clk) begin
        if (reset) begin
            s_run     <= 1'b0;
            s_cnt     <= 0;
            s_x       <= '0;
            s_y       <= '0;
            div_valid <= 1'b0;
            div_dbz   <= 1'b0;
            div_q     <= '0;
            div_r     <= '0;
        end else begin
            div_valid <= inj;
            if (inj) begin
                div_q <= 16'hdead;
                div_r <= 16'hbeef;
            end
            if (div_start) begin
                s_x     <= div_x;
                s_y     <= div_y;
                div_dbz <= (div_y == 0);
                s_run   <= (div_y != 0);
                s_cnt   <= WIDTH;
            end else if (s_run) begin
                s_cnt <= s_cnt - 1;
                if (s_cnt == 1) begin
                    s_run <= 1'b0;
                    if (!hang) begin
                        div_valid <= 1'b1;
                        div_q     <= s_x / s_y;
                        div_r     <= s_x % s_y;
                    end
                end
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    int               cyc = 0;
    bit               m_busy = 0;
    int               m_owner, m_acc;
    int               m_rr = NUM_REQ - 1;
    logic [WIDTH-1:0] m_x, m_y;
    logic [WIDTH-1:0] op_x [NUM_REQ];
    logic [WIDTH-1:0] op_y [NUM_REQ];
    bit               auto_drop = 1;
    logic [NUM_REQ-1:0] drop_mask = '0;
    int               grants[$];
    int               n_start = 0, n_rsp = 0;
    int               last_lat, last_q, last_r, last_dbz, last_err;

    task automatic model_check();
        logic [NUM_REQ-1:0] e_ready, e_rsp;
        logic e_start;
        int lat, g;
        e_ready = '0;
        e_rsp   = '0;
        e_start = 1'b0;
        g       = 0;
        if (reset) begin
            m_busy = 0;
            m_rr   = NUM_REQ - 1;
            return;
        end
        if (m_busy) begin
            lat     = (m_y == 0) ? 3 : (hang ? 3 + TIMEOUT : WIDTH + 3);
            e_start = (cyc == m_acc + 1);
            if (cyc == m_acc + lat) e_rsp[m_owner] = 1'b1;
        end else begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                if (e_ready == 0 && req_valid[(m_rr + i) % NUM_REQ]) begin
                    g = (m_rr + i) % NUM_REQ;
                    e_ready[g] = 1'b1;
                end
            end
        end
        if (div_start) n_start++;
        chk("req_ready", 64'(req_ready), 64'(e_ready));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
        chk("div_start", 64'(div_start), 64'(e_start));
        if (rsp_valid != 0) begin
            n_rsp++;
            last_lat = cyc - m_acc;
            last_q   = int'(rsp_q);
            last_r   = int'(rsp_r);
            last_dbz = int'(rsp_dbz);
            last_err = int'(rsp_err);
        end
        if (e_rsp != 0) begin
            if (m_y == 0 || hang) begin
                chk("rsp_q", 64'(rsp_q), 0);
                chk("rsp_r", 64'(rsp_r), 0);
            end else begin
                chk("rsp_q", 64'(rsp_q), 64'(m_x / m_y));
                chk("rsp_r", 64'(rsp_r), 64'(m_x % m_y));
            end
            chk("rsp_dbz", 64'(rsp_dbz), 64'(m_y == 0));
            chk("rsp_err", 64'(rsp_err), 64'(m_y != 0 && hang));
            m_busy = 0;
        end else begin
            chk("rsp_idle", 64'({rsp_q, rsp_r, rsp_dbz, rsp_err}), 0);
        end
        if (m_busy && cyc == m_acc + 1) begin
            chk("div_x", 64'(div_x), 64'(m_x));
            chk("div_y", 64'(div_y), 64'(m_y));
        end
        if (e_ready != 0) begin
            m_busy  = 1;
            m_owner = g;
            m_x     = op_x[g];
            m_y     = op_y[g];
            m_acc   = cyc;
            m_rr    = g;
            grants.push_back(g);
            if (auto_drop) drop_mask[g] = 1'b1;
        end
    endtask

    // Sample the current cycle on the falling edge, then move to just after the next rising edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            model_check();
            @(posedge clk);
            #1;
            cyc++;
            req_valid = req_valid & ~drop_mask;
            drop_mask = '0;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((req_valid != 0 || m_busy) && n < budget) begin
            run(1);
            n++;
        end
        if (req_valid != 0 || m_busy) begin
            n_checks++;
            n_errors++;
            $error("FAIL drain_budget: observed %0d cycles expected fewer", n);
        end
    endtask

    task automatic set_req(input int k, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        op_x[k] = x;
        op_y[k] = y;
        req_x[k*WIDTH +: WIDTH] = x;
        req_y[k*WIDTH +: WIDTH] = y;
        req_valid[k] = 1'b1;
    endtask

    initial begin
        int exp_ord[5];
        int rsp0, mask, wait_n;
        logic [WIDTH-1:0] rx, ry;

        reset     = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        @(posedge clk);
        #1;
        run(3);
        reset = 1'b0;
        chk("reset_div_x", 64'(div_x), 0);
        chk("reset_div_y", 64'(div_y), 0);
        run(2);

        // Basic divide: 1000 / 7
        set_req(0, 16'd1000, 16'd7);
        drain(100);
        chk("t1_latency", 64'(last_lat), 19);
        chk("t1_q", 64'(last_q), 142);
        chk("t1_r", 64'(last_r), 6);
        chk("t1_dbz", 64'(last_dbz), 0);
        chk("t1_err", 64'(last_err), 0);

        // Divide by zero, then a normal op
        n_start = 0;
        set_req(2, 16'd55, 16'd0);
        drain(100);
        chk("t2_latency", 64'(last_lat), 3);
        chk("t2_dbz", 64'(last_dbz), 1);
        chk("t2_q", 64'(last_q), 0);
        chk("t2_starts", 64'(n_start), 1);
        set_req(1, 16'd100, 16'd9);
        drain(100);
        chk("t2_next_q", 64'(last_q), 11);
        chk("t2_next_r", 64'(last_r), 1);
        chk("t2_next_dbz", 64'(last_dbz), 0);

        // All four held from reset: round robin 0,1,2,3,0
        reset = 1'b1;
        run(2);
        auto_drop = 0;
        set_req(0, 16'd1000, 16'd7);
        set_req(1, 16'd500, 16'd3);
        set_req(2, 16'hFFFF, 16'd255);
        set_req(3, 16'd12345, 16'd100);
        run(1);
        reset = 1'b0;
        grants.delete();
        wait_n = 0;
        while (grants.size() < 5 && wait_n < 400) begin
            run(1);
            wait_n++;
        end
        req_valid = '0;
        auto_drop = 1;
        drain(100);
        exp_ord = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) chk("t3_grant_order", 64'(grants[i]), 64'(exp_ord[i]));

        // Reset in RUN cycle 8 of an op for req1
        rsp0 = n_rsp;
        set_req(1, 16'd40000, 16'd13);
        run(1);
        while (cyc < m_acc + 11) run(1);
        reset = 1'b1;
        set_req(1, 16'd40000, 16'd13);
        set_req(3, 16'd777, 16'd5);
        run(1);
        chk("t4_no_rsp", 64'(n_rsp - rsp0), 0);
        reset = 1'b0;
        grants.delete();
        drain(200);
        chk("t4_first", 64'(grants[0]), 1);
        chk("t4_second", 64'(grants[1]), 3);

        // Watchdog: divider never answers
        hang = 1'b1;
        set_req(0, 16'd10, 16'd3);
        drain(100);
        chk("t5_err", 64'(last_err), 1);
        chk("t5_latency", 64'(last_lat), 64'(3 + TIMEOUT));
        chk("t5_q", 64'(last_q), 0);
        hang = 1'b0;
        set_req(3, 16'd99, 16'd10);
        drain(100);
        chk("t5_after_q", 64'(last_q), 9);
        chk("t5_after_err", 64'(last_err), 0);

        // Boundaries
        set_req(0, 16'hFFFF, 16'd1);
        drain(100);
        chk("t6_max_q", 64'(last_q), 64'h FFFF);
        chk("t6_max_r", 64'(last_r), 0);
        set_req(2, 16'd3, 16'hFFFF);
        drain(100);
        chk("t6_small_q", 64'(last_q), 0);
        chk("t6_small_r", 64'(last_r), 3);
        rsp0 = n_rsp;
        inj = 1'b1;
        run(1);
        inj = 1'b0;
        run(4);
        chk("t6_inject_no_rsp", 64'(n_rsp - rsp0), 0);

        // A request raised mid-operation and withdrawn before IDLE is never served
        rsp0 = n_rsp;
        grants.delete();
        set_req(0, 16'd300, 16'd4);
        run(2);
        set_req(2, 16'd77, 16'd7);
        run(5);
        req_valid[2] = 1'b0;
        drain(100);
        chk("withdraw_rsp_count", 64'(n_rsp - rsp0), 1);
        chk("withdraw_grants", 64'(grants.size()), 1);

        // Random mixes of simultaneous requests
        for (int it = 0; it < 30; it++) begin
            mask = $urandom_range(1, (1 << NUM_REQ) - 1);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (mask[k]) begin
                    rx = WIDTH'($urandom);
                    case ($urandom_range(0, 3))
                        0: ry = '0;
                        1: ry = WIDTH'($urandom_range(1, 15));
                        default: ry = WIDTH'($urandom_range(1, 65535));
                    endcase
                    set_req(k, rx, ry);
                end
            end
            drain(NUM_REQ * (WIDTH + 6) + 10);
            run($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "global timeout");
    end

endmodule
